// File: rtl/input_request_unit_if.sv
// Handshake bundle between one router input port, its upstream link and the switch controller.
// slave = the input request unit; master = the surrounding router / bench.
interface input_request_unit_if #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int M      = 5
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [DATA_W-1:0] i_data;
  logic              i_data_val;
  logic              i_input_grant;
  logic              o_en;
  logic [DATA_W-1:0] o_data;
  logic              o_data_val;
  logic [0:M-1]      o_output_req;
  logic              o_overflow;
  logic [CNT_W-1:0]  o_count;

  modport slave (
    input  i_data, i_data_val, i_input_grant,
    output o_en, o_data, o_data_val, o_output_req, o_overflow, o_count
  );

  modport master (
    output i_data, i_data_val, i_input_grant,
    input  o_en, o_data, o_data_val, o_output_req, o_overflow, o_count
  );
endinterface

// File: rtl/input_request_unit.sv
// Router input port: flit FIFO plus XY route of the head flit, one-hot request to the switch; 1-cycle write-to-head latency.
// Backpressure: o_en drops when full; a write while full and not popped is dropped and flagged on o_overflow.
module input_request_unit #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int X_W    = 2,
  parameter int Y_W    = 2,
  parameter int M      = 5,
  parameter int LOC_X  = 0,
  parameter int LOC_Y  = 0
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                ce,
  input_request_unit_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [X_W-1:0] LX = X_W'(LOC_X);
  localparam logic [Y_W-1:0] LY = Y_W'(LOC_Y);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              overflow_q, overflow_d;

  logic              full, empty, rd, wr;
  logic [DATA_W-1:0] head;
  logic [X_W-1:0]    dest_x;
  logic [Y_W-1:0]    dest_y;
  logic [0:M-1]      req;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign rd    = ce & bus.i_input_grant & ~empty;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts.
  assign wr    = ce & bus.i_data_val & (~full | rd);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = ce & bus.i_data_val & full & ~rd;
    if (wr) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd) rd_ptr_d = rd_ptr_q + 1'b1;
    if (wr && !rd)      count_d = count_q + 1'b1;
    else if (rd && !wr) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem_q[wr_ptr_q] <= bus.i_data;
  end

  assign head   = empty ? '0 : mem_q[rd_ptr_q];
  assign dest_x = head[X_W+Y_W-1:Y_W];
  assign dest_y = head[Y_W-1:0];

  // XY dimension-order routing: resolve X before Y.
  always_comb begin
    req = '0;
    if (!empty) begin
      if (dest_x > LX)      req[2] = 1'b1;
      else if (dest_x < LX) req[4] = 1'b1;
      else if (dest_y < LY) req[1] = 1'b1;
      else if (dest_y > LY) req[3] = 1'b1;
      else                  req[0] = 1'b1;
    end
  end

  assign bus.o_en         = ~full;
  assign bus.o_data       = head;
  assign bus.o_data_val   = ~empty;
  assign bus.o_output_req = req;
  assign bus.o_overflow   = overflow_q;
  assign bus.o_count      = count_q;
endmodule

// File: tb/tb_input_request_unit.sv
// Directed bench for input_request_unit at router position (1,1), DEPTH 4.
module tb_input_request_unit;
  logic clk = 1'b0;
  logic reset_n;
  logic ce;
  int   tests = 0;
  int   fails = 0;

  input_request_unit_if #(.DATA_W(32), .DEPTH(4), .M(5)) bus ();

  input_request_unit #(
    .DATA_W(32), .DEPTH(4), .X_W(2), .Y_W(2), .M(5), .LOC_X(1), .LOC_Y(1)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .ce     (ce),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [1:0] x, input logic [1:0] y, input logic [7:0] tag);
    return {20'h0, tag, x, y};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] f [0:3];
  logic [31:0] g [0:4];
  logic [31:0] h [0:13];
  logic [31:0] k [0:2];

  initial begin
    for (int i = 0; i < 14; i++) h[i] = mk(2'(i), 2'(i + 1), 8'(8'h40 + i));
    for (int i = 0; i < 5; i++)  g[i] = mk(2'(i), 2'(i + 2), 8'(8'h20 + i));
    for (int i = 0; i < 3; i++)  k[i] = mk(2'(i), 2'(i), 8'(8'h80 + i));
    f[0] = mk(2'd3, 2'd0, 8'h10);
    f[1] = mk(2'd0, 2'd2, 8'h11);
    f[2] = mk(2'd1, 2'd0, 8'h12);
    f[3] = mk(2'd1, 2'd3, 8'h13);

    reset_n = 1'b0;
    ce = 1'b1;
    bus.i_data = '0;
    bus.i_data_val = 1'b0;
    bus.i_input_grant = 1'b0;

    // 1: reset state
    #3;
    chk("rst_en",    64'(bus.o_en), 64'd1);
    chk("rst_req",   64'(bus.o_output_req), 64'h0);
    chk("rst_val",   64'(bus.o_data_val), 64'd0);
    chk("rst_count", 64'(bus.o_count), 64'd0);
    chk("rst_data",  64'(bus.o_data), 64'h0);
    chk("rst_ovf",   64'(bus.o_overflow), 64'd0);
    #9 reset_n = 1'b1;
    tick();

    // 2: local flit, one-cycle latency, pop on grant
    bus.i_data = mk(2'd1, 2'd1, 8'hA5);
    bus.i_data_val = 1'b1;
    tick();
    bus.i_data_val = 1'b0;
    chk("t2_req",   64'(bus.o_output_req), 64'(5'b10000));
    chk("t2_val",   64'(bus.o_data_val), 64'd1);
    chk("t2_data",  64'(bus.o_data), 64'(mk(2'd1, 2'd1, 8'hA5)));
    chk("t2_count", 64'(bus.o_count), 64'd1);
    bus.i_input_grant = 1'b1;
    tick();
    bus.i_input_grant = 1'b0;
    chk("t2_req_pop",   64'(bus.o_output_req), 64'h0);
    chk("t2_count_pop", 64'(bus.o_count), 64'd0);
    chk("t2_val_pop",   64'(bus.o_data_val), 64'd0);

    // 3: streaming, grant every cycle, each route direction
    bus.i_data = f[0];
    bus.i_data_val = 1'b1;
    tick();
    chk("t3_req0",  64'(bus.o_output_req), 64'(5'b00100));
    chk("t3_data0", 64'(bus.o_data), 64'(f[0]));
    bus.i_data = f[1];
    bus.i_input_grant = 1'b1;
    tick();
    chk("t3_req1",  64'(bus.o_output_req), 64'(5'b00001));
    chk("t3_data1", 64'(bus.o_data), 64'(f[1]));
    bus.i_data = f[2];
    tick();
    chk("t3_req2",  64'(bus.o_output_req), 64'(5'b01000));
    chk("t3_data2", 64'(bus.o_data), 64'(f[2]));
    bus.i_data = f[3];
    tick();
    chk("t3_req3",   64'(bus.o_output_req), 64'(5'b00010));
    chk("t3_data3",  64'(bus.o_data), 64'(f[3]));
    chk("t3_count3", 64'(bus.o_count), 64'd1);
    bus.i_data_val = 1'b0;
    tick();
    bus.i_input_grant = 1'b0;
    chk("t3_empty", 64'(bus.o_count), 64'd0);

    // 4: fill, overflow pulse, drain in order
    for (int i = 0; i < 4; i++) begin
      bus.i_data = g[i];
      bus.i_data_val = 1'b1;
      tick();
    end
    chk("t4_count_full", 64'(bus.o_count), 64'd4);
    chk("t4_en_full",    64'(bus.o_en), 64'd0);
    chk("t4_ovf_pre",    64'(bus.o_overflow), 64'd0);
    bus.i_data = g[4];
    tick();
    bus.i_data_val = 1'b0;
    chk("t4_ovf",       64'(bus.o_overflow), 64'd1);
    chk("t4_count_ovf", 64'(bus.o_count), 64'd4);
    tick();
    chk("t4_ovf_clr", 64'(bus.o_overflow), 64'd0);
    bus.i_input_grant = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t4_drain%0d", i), 64'(bus.o_data), 64'(g[i]));
      tick();
    end
    bus.i_input_grant = 1'b0;
    chk("t4_drained", 64'(bus.o_count), 64'd0);
    chk("t4_en_back", 64'(bus.o_en), 64'd1);

    // 5: full FIFO with simultaneous write and pop, pointers wrap
    for (int i = 0; i < 4; i++) begin
      bus.i_data = h[i];
      bus.i_data_val = 1'b1;
      tick();
    end
    bus.i_input_grant = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("t5_head%0d", i), 64'(bus.o_data), 64'(h[i]));
      bus.i_data = h[i + 4];
      tick();
      chk($sformatf("t5_count%0d", i), 64'(bus.o_count), 64'd4);
      chk($sformatf("t5_ovf%0d", i), 64'(bus.o_overflow), 64'd0);
    end
    bus.i_data_val = 1'b0;
    for (int i = 10; i < 14; i++) begin
      chk($sformatf("t5_drain%0d", i), 64'(bus.o_data), 64'(h[i]));
      tick();
    end
    bus.i_input_grant = 1'b0;
    chk("t5_empty", 64'(bus.o_count), 64'd0);

    // 6: clock enable low freezes state, then async reset clears
    for (int i = 0; i < 3; i++) begin
      bus.i_data = k[i];
      bus.i_data_val = 1'b1;
      tick();
    end
    ce = 1'b0;
    bus.i_data = mk(2'd3, 2'd3, 8'hEE);
    bus.i_input_grant = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("t6_ce_count%0d", i), 64'(bus.o_count), 64'd3);
      chk($sformatf("t6_ce_head%0d", i), 64'(bus.o_data), 64'(k[0]));
    end
    ce = 1'b1;
    bus.i_data_val = 1'b0;
    bus.i_input_grant = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("t6_rst_count", 64'(bus.o_count), 64'd0);
    chk("t6_rst_en",    64'(bus.o_en), 64'd1);
    chk("t6_rst_req",   64'(bus.o_output_req), 64'h0);
    chk("t6_rst_val",   64'(bus.o_data_val), 64'd0);
    #2 reset_n = 1'b1;
    tick();
    chk("t6_post_count", 64'(bus.o_count), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/input_request_unit.md
Name: input_request_unit

Overview:
- Per-input-port front end of the router: the requesting side of the output-arbitration handshake, feeding one row of the switch controller's request matrix.
- Buffers incoming flits and computes the XY route of the head flit.
- Presents a one-hot output-port request and pops the head flit when the switch controller grants this input.
- Drives the enable back to the upstream router, so it also closes the link-level flow-control loop.

Parameters:
- DATA_W, 32, flit width in bits; dest address in low bits: {dest_x, dest_y} = data[X_W+Y_W-1:0], dest_y in the LSBs.
- DEPTH, 4, FIFO entries; power of two, >=2.
- X_W, 2, x-coordinate width.
- Y_W, 2, y-coordinate width.
- M, 5, output ports; index 0 Local, 1 North, 2 East, 3 South, 4 West.
- LOC_X, 0, this router's x coordinate.
- LOC_Y, 0, this router's y coordinate.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- ce  in  1  clock enable; when low, no state changes.
- i_data  in  DATA_W  flit from upstream.
- i_data_val  in  1  flit valid from upstream.
- o_en  out  1  space available; drives upstream router's enable.
- o_data  out  DATA_W  head flit, to switch.
- o_data_val  out  1  FIFO not empty.
- o_output_req  out  [0:M-1]  one-hot request for head flit's output port; all zero when empty.
- i_input_grant  in  1  this input's bit of the controller's input grant; pops head.
- o_overflow  out  1  one-cycle pulse: write dropped because full.
- o_count  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (async assert, sync release): wr_ptr = rd_ptr = count = 0; o_en = 1; o_data_val = 0; o_data = 0; o_output_req = 0; o_overflow = 0.
- Storage: circular buffer of DEPTH entries; pointers wrap mod DEPTH; count tracks occupancy 0..DEPTH.
- All register updates are qualified by ce. With ce = 0, pointers, count and memory hold, o_overflow = 0, and combinational outputs reflect the held state.
- write = ce & i_data_val & (count<DEPTH | read).
- read = ce & i_input_grant & (count>0). A grant while empty is ignored.
- Simultaneous read and write:
  - count unchanged;
  - allowed when full; the write succeeds into the slot freed by the read;
  - when count = 1, the new flit becomes head next cycle.
- Overflow: ce & i_data_val & count = DEPTH & !read. Flit dropped; o_overflow = 1 for exactly the next cycle (registered).
- o_en = (count < DEPTH), combinational from registered count. Upstream may write in any cycle o_en is high.
- Latency: flit written in cycle t into an empty FIFO appears on o_data / o_data_val / o_output_req in cycle t+1. There is no bypass path.
- o_data = mem[rd_ptr] when count>0, else 0.
- Route (combinational from head, XY dimension order, X first):
  - dest_x > LOC_X -> East (bit 2);
  - dest_x < LOC_X -> West (bit 4);
  - dest_x == LOC_X and dest_y < LOC_Y -> North (bit 1);
  - dest_x == LOC_X and dest_y > LOC_Y -> South (bit 3);
  - both equal -> Local (bit 0).
- Exactly one bit of o_output_req is set when count>0.
- Request persistence: o_output_req stays asserted and unchanged until the cycle a grant pops the head. The next head's request appears the following cycle.
- Back-to-back: a grant every cycle drains one flit per cycle.
- o_count = count.
- Reset mid-operation: all buffered flits are discarded immediately; o_en returns to 1 asynchronously.

Test Plan:
1. Reset, LOC=(1,1): o_en=1, o_output_req=00000, o_data_val=0, o_count=0.
2. Write flit dest (1,1) at t, no grant: at t+1 o_output_req=10000, o_data_val=1. Grant at t+1: at t+2 o_output_req=00000, o_count=0.
3. Write flits with dest (3,0), (0,2), (1,0), (1,3) in consecutive cycles; grant each cycle from first valid:
   - requests in order 00100, 00001, 01000, 00010;
   - o_data matches each flit in order.
4. Fill DEPTH=4 with no grants: o_count=4, o_en=0. 5th write -> o_overflow=1 next cycle only; o_count stays 4; later drain shows original 4 flits in order.
5. When full, write and grant in the same cycle: o_count stays 4, no overflow. Wrap pointers over 10 such cycles; data order preserved.
6. ce=0 with i_data_val and i_input_grant high for 3 cycles: no change in count or head. Assert reset_n=0 with 3 flits stored: o_count=0, o_en=1, o_output_req=0 immediately.
